// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with valid/ready handshakes on operand and result sides.
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] KLast = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_acc;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout, r_ovf, r_out_valid;

   logic             w_accept, w_last, w_msb_cin;
   logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
   logic [CHUNK:0]   w_chunk_sum;
   logic [WIDTH-1:0] w_acc_nxt;

   assign o_in_ready = (r_state == StIdle) && i_rst_n;
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_last     = (r_k == KLast);

   always_comb begin
      w_a_chunk   = r_a[r_k*CHUNK +: CHUNK];
      w_b_chunk   = r_b[r_k*CHUNK +: CHUNK];
      w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
      w_acc_nxt   = r_acc;
      w_acc_nxt[r_k*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
      // Carry into the MSB recovered from its sum bit; valid on the last chunk.
      w_msb_cin   = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk_sum[CHUNK-1];
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_nxt = StRun;
         StRun:   if (w_last) w_state_nxt = StDone;
         StDone:  if (i_out_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_k         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_a     <= i_a;
                  r_b     <= i_sub ? ~i_b : i_b;
                  r_carry <= i_sub ? ~i_cin : i_cin;
                  r_k     <= '0;
               end
            end
            StRun: begin
               r_acc   <= w_acc_nxt;
               r_carry <= w_chunk_sum[CHUNK];
               r_k     <= r_k + KW'(1);
               if (w_last) begin
                  r_sum       <= w_acc_nxt;
                  r_cout      <= w_chunk_sum[CHUNK];
                  r_ovf       <= w_msb_cin ^ w_chunk_sum[CHUNK];
                  r_out_valid <= 1'b1;
               end
            end
            StDone: begin
               if (i_out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_sum       = r_sum;
   assign o_cout      = r_cout;
   assign o_ovf       = r_ovf;

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, and holds the inter-chunk carry in a register. It generalises the combinational ripple-carry adders in the adders library to arbitrary width, adds a subtract mode and a signed-overflow flag, and uses valid/ready handshakes on both sides. It trades latency for a short per-cycle carry chain and sits between operand-producing logic and any result consumer.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK, with 1 ≤ NCHUNK.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (in sub mode, 1 = no borrow).
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- in_ready = (state == IDLE) && rst_n. Operands are accepted only on in_valid && in_ready.
- On accept, capture:
  - A_r = a
  - B_r = sub ? ~b : b
  - carry_r = sub ? ~cin : cin
  - chunk index k = 0
  - then go to RUN.
- RUN, each cycle:
  - {c, s} = A_r[k*CHUNK +: CHUNK] + B_r[k*CHUNK +: CHUNK] + carry_r
  - write s into the internal accumulator at chunk k, set carry_r = c, k++.
  - On the last chunk (k == NCHUNK−1), also compute the carry into the MSB bit, then go to DONE.
- On RUN→DONE, load the output registers:
  - sum = accumulator
  - cout = final carry
  - ovf = (carry into MSB) XOR (carry out of MSB)
  - out_valid = 1
- DONE:
  - Hold sum/cout/ovf/out_valid stable until out_valid && out_ready, then go to IDLE with out_valid = 0.
  - in_valid is ignored while in DONE or RUN.
- sum, cout and ovf keep the last completed result while in IDLE and RUN. They only change on RUN→DONE.
- Operand inputs are sampled only at accept. Changes to them during RUN have no effect.
- With NCHUNK = 1, RUN lasts exactly one cycle.
- Reset mid-operation (any state): discard the in-flight op and return to IDLE. Nothing partial is ever presented.

## Timing
- All outputs are registered except in_ready, which is combinational from state and rst_n.
- Reset values: out_valid 0, sum 0, cout 0, ovf 0, state IDLE, k 0, carry_r 0. in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Latency: accept at edge E gives out_valid high after edge E+NCHUNK. This holds regardless of operand values, because every chunk is always processed.
- Minimum spacing between accepts is NCHUNK+2 cycles, reached when out_ready is held high:
  - 1 cycle in IDLE
  - NCHUNK cycles in RUN
  - 1 cycle in DONE
- Accept and result handshakes never coincide in the same cycle, since in_ready is 0 in DONE.
- Asynchronous reset assertion clears outputs immediately. Deassertion is used synchronously with clk by the surrounding design.

## Test plan
- Reset:
  - Drive rst_n low mid-cycle → out_valid, sum, cout, ovf go 0 immediately.
  - After release → in_ready = 1 and out_valid stays 0 until the first accept.
- Full carry ripple (WIDTH 16, CHUNK 4): a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. out_valid rises exactly 4 cycles after accept.
- Signed overflow:
  - a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1.
  - sub with a=0x8000, b=0x0001, cin=0 → sum=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. With cin=1 → sum=0xFFFD.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands.
  - sum, cout, ovf and out_valid stay stable; in_ready stays 0.
  - On the out_ready pulse, the block returns to IDLE and the next accept occurs one cycle later.
- Reset mid-RUN and alternate configs:
  - Pull rst_n low after 2 chunks → no out_valid, all outputs 0. A new op after release completes correctly.
  - WIDTH=4, CHUNK=1: a=0xE, b=0xA, cin=1 → sum=0x9, cout=1, latency 4.
  - WIDTH=16, CHUNK=16: same vector as the full-carry-ripple scenario, latency 1.
